// File: rtl/embedded_io_pkg.sv
// Shared types and defaults for the embedded IO synchronizer.
// Holds the per-bit direction state encoding and a counter-width helper.
package embedded_io_pkg;

    typedef enum logic [1:0] {
        IN   = 2'd0,
        TURN = 2'd1,
        OUT  = 2'd2
    } dir_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_FILT_LEN = 3;
    localparam int DEF_TURN_CYC = 2;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/embedded_io_sync_bit.sv
// One embedded IO bit: two-flop input synchronizer, optional glitch filter,
// and the IN/TURN/OUT direction FSM driving the pad output and enable.
// Glitch filter is compiled in when EMBEDDED_IO_GLITCH_FILTER_EN is defined.
module embedded_io_sync_bit
    import embedded_io_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic soc_in,
    input  logic fpga_out,
    input  logic fpga_dir,
    output logic fpga_in,
    output logic soc_out,
    output logic soc_dir
);

    localparam int TW = cnt_w(TURN_CYC);

    logic s1, s2;

    // Two-flop synchronizer for the asynchronous pad input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= soc_in;
            s2 <= s1;
        end
    end

`ifdef EMBEDDED_IO_GLITCH_FILTER_EN
    localparam int FW = cnt_w(FILT_LEN);
    logic [FW-1:0] fcnt;

    // Accept a new s2 level only after it has differed for FILT_LEN cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpga_in <= 1'b0;
            fcnt    <= '0;
        end else if (s2 == fpga_in) begin
            fcnt <= '0;
        end else if (int'(fcnt) == FILT_LEN - 1) begin
            fpga_in <= s2;
            fcnt    <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end
`else
    assign fpga_in = s2;
`endif

    dir_state_t    state;
    logic [TW-1:0] tcnt;

    // Direction FSM; pad outputs are registered from the next state so the
    // pad only drives data while the enable is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IN;
            tcnt    <= '0;
            soc_dir <= 1'b0;
            soc_out <= 1'b0;
        end else begin
            soc_dir <= 1'b0;
            soc_out <= 1'b0;
            unique case (state)
                IN: begin
                    if (fpga_dir) begin
                        if (TURN_CYC == 0) begin
                            state   <= OUT;
                            soc_dir <= 1'b1;
                            soc_out <= fpga_out;
                        end else begin
                            state <= TURN;
                            tcnt  <= '0;
                        end
                    end
                end
                TURN: begin
                    if (!fpga_dir) begin
                        state <= IN;
                    end else if (int'(tcnt) == TURN_CYC - 1) begin
                        state   <= OUT;
                        soc_dir <= 1'b1;
                        soc_out <= fpga_out;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                OUT: begin
                    if (!fpga_dir) begin
                        state <= IN;
                    end else begin
                        soc_dir <= 1'b1;
                        soc_out <= fpga_out;
                    end
                end
                default: state <= IN;
            endcase
        end
    end

endmodule

// File: rtl/embedded_io_sync.sv
// Embedded IO synchronizer top: WIDTH independent pad bits, each with an
// input synchronizer/filter and a turnaround-protected output enable.
// Define EMBEDDED_IO_GLITCH_FILTER_EN to compile in the input glitch filter.
module embedded_io_sync
    import embedded_io_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int FILT_LEN = DEF_FILT_LEN,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SOC_IN,
    output logic [WIDTH-1:0] FPGA_IN,
    input  logic [WIDTH-1:0] FPGA_OUT,
    input  logic [WIDTH-1:0] FPGA_DIR,
    output logic [WIDTH-1:0] SOC_OUT,
    output logic [WIDTH-1:0] SOC_DIR
);

    // One fully independent slice per pad bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        embedded_io_sync_bit #(
            .FILT_LEN (FILT_LEN),
            .TURN_CYC (TURN_CYC)
        ) u_bit (
            .clk      (CLK),
            .rst      (RST),
            .soc_in   (SOC_IN[i]),
            .fpga_out (FPGA_OUT[i]),
            .fpga_dir (FPGA_DIR[i]),
            .fpga_in  (FPGA_IN[i]),
            .soc_out  (SOC_OUT[i]),
            .soc_dir  (SOC_DIR[i])
        );
    end

endmodule

// File: tb/tb_embedded_io_sync.sv
// Directed bench for embedded_io_sync: expectations are queued with a due
// cycle as stimulus is driven and compared after that clock edge.
module tb_embedded_io_sync;

`ifdef EMBEDDED_IO_GLITCH_FILTER_EN
    localparam int FL = 5;   // 2 sync + FILT_LEN(3)
    localparam bit FILT = 1'b1;
`else
    localparam int FL = 2;
    localparam bit FILT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SOC_IN, FPGA_OUT, FPGA_DIR;
    logic [7:0] FPGA_IN, SOC_OUT, SOC_DIR;
    logic [7:0] FPGA_IN0, SOC_OUT0, SOC_DIR0;

    always #5 CLK = ~CLK;

    embedded_io_sync #(.WIDTH(8), .FILT_LEN(3), .TURN_CYC(2)) dut (
        .CLK(CLK), .RST(RST), .SOC_IN(SOC_IN), .FPGA_IN(FPGA_IN),
        .FPGA_OUT(FPGA_OUT), .FPGA_DIR(FPGA_DIR), .SOC_OUT(SOC_OUT), .SOC_DIR(SOC_DIR)
    );

    embedded_io_sync #(.WIDTH(8), .FILT_LEN(3), .TURN_CYC(0)) dut0 (
        .CLK(CLK), .RST(RST), .SOC_IN(SOC_IN), .FPGA_IN(FPGA_IN0),
        .FPGA_OUT(FPGA_OUT), .FPGA_DIR(FPGA_DIR), .SOC_OUT(SOC_OUT0), .SOC_DIR(SOC_DIR0)
    );

    typedef enum int {S_FIN, S_SOUT, S_SDIR, S_FIN0, S_SOUT0, S_SDIR0} sig_t;

    typedef struct {
        string      tag;
        int         due;
        sig_t       sig;
        logic [7:0] mask;
        logic [7:0] val;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;

    function automatic logic [7:0] get_sig(input sig_t s);
        case (s)
            S_FIN:   return FPGA_IN;
            S_SOUT:  return SOC_OUT;
            S_SDIR:  return SOC_DIR;
            S_FIN0:  return FPGA_IN0;
            S_SOUT0: return SOC_OUT0;
            default: return SOC_DIR0;
        endcase
    endfunction

    // Queue an expectation checked just after the edge dly cycles from now.
    task automatic expect_at(input string tag, input int dly, input sig_t s,
                             input logic [7:0] mask, input logic [7:0] val);
        sb_t e;
        e.tag = tag; e.due = cyc + dly; e.sig = s; e.mask = mask; e.val = val & mask;
        sb.push_back(e);
    endtask

    task automatic check(input sb_t e);
        logic [7:0] obs;
        obs = get_sig(e.sig) & e.mask;
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %h expected %h (mask %h)",
                   e.tag, cyc, obs, e.val, e.mask);
        end
    endtask

    task automatic tick();
        sb_t keep[$];
        @(posedge CLK);
        #1;
        cyc++;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) check(sb[i]);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RST = 1'b1; SOC_IN = '0; FPGA_OUT = '0; FPGA_DIR = '0;
        ticks(2);

        // Reset state
        expect_at("rst_fin",  1, S_FIN,  8'hFF, 8'h00);
        expect_at("rst_sout", 1, S_SOUT, 8'hFF, 8'h00);
        expect_at("rst_sdir", 1, S_SDIR, 8'hFF, 8'h00);
        tick();

        // Input latency on bit 0
        RST = 1'b0;
        SOC_IN[0] = 1'b1;
        expect_at("lat_b0_pre",  FL - 1, S_FIN, 8'h01, 8'h00);
        expect_at("lat_b0_rise", FL,     S_FIN, 8'h01, 8'h01);
        ticks(FL + 1);

        // Two-cycle pulse on bit 1
        if (FILT) begin
            for (int d = 1; d <= 7; d++) expect_at("glitch2_b1", d, S_FIN, 8'h02, 8'h00);
        end else begin
            expect_at("pulse2_b1_hi", 2, S_FIN, 8'h02, 8'h02);
            expect_at("pulse2_b1_hi", 3, S_FIN, 8'h02, 8'h02);
            expect_at("pulse2_b1_lo", 4, S_FIN, 8'h02, 8'h00);
        end
        SOC_IN[1] = 1'b1; ticks(2);
        SOC_IN[1] = 1'b0; ticks(6);

        // Three-cycle pulse on bit 1
        if (FILT) begin
            expect_at("pulse3_b1_pre", 4, S_FIN, 8'h02, 8'h00);
            for (int d = 5; d <= 7; d++) expect_at("pulse3_b1_hi", d, S_FIN, 8'h02, 8'h02);
            expect_at("pulse3_b1_lo", 8, S_FIN, 8'h02, 8'h00);
        end else begin
            for (int d = 2; d <= 4; d++) expect_at("pulse3_b1_hi", d, S_FIN, 8'h02, 8'h02);
            expect_at("pulse3_b1_lo", 5, S_FIN, 8'h02, 8'h00);
        end
        SOC_IN[1] = 1'b1; ticks(3);
        SOC_IN[1] = 1'b0; ticks(6);

        // Turnaround on bit 2 (TURN_CYC=2) and direct drive (TURN_CYC=0)
        FPGA_OUT[2] = 1'b1; FPGA_DIR[2] = 1'b1;
        expect_at("turn_b2_dir0", 1, S_SDIR, 8'h04, 8'h00);
        expect_at("turn_b2_dir1", 2, S_SDIR, 8'h04, 8'h00);
        expect_at("turn_b2_out1", 2, S_SOUT, 8'h04, 8'h00);
        expect_at("turn_b2_dir2", 3, S_SDIR, 8'h04, 8'h04);
        expect_at("turn_b2_out2", 3, S_SOUT, 8'h04, 8'h04);
        expect_at("t0_b2_dir",    1, S_SDIR0, 8'h04, 8'h04);
        expect_at("t0_b2_out",    1, S_SOUT0, 8'h04, 8'h04);
        ticks(4);

        // Data follows fabric while driving
        FPGA_OUT[2] = 1'b0;
        expect_at("out_b2_data0", 1, S_SOUT, 8'h04, 8'h00);
        expect_at("out_b2_dirhold", 1, S_SDIR, 8'h04, 8'h04);
        ticks(2);

        // Release from OUT on bit 3
        FPGA_OUT[3] = 1'b1; FPGA_DIR[3] = 1'b1;
        expect_at("drv_b3_dir", 3, S_SDIR, 8'h08, 8'h08);
        ticks(4);
        FPGA_DIR[3] = 1'b0;
        expect_at("rel_b3_dir", 1, S_SDIR, 8'h08, 8'h00);
        expect_at("rel_b3_out", 1, S_SOUT, 8'h08, 8'h00);
        ticks(2);
        FPGA_OUT[3] = 1'b0;

        // One-cycle direction pulse on bit 4 must never drive
        FPGA_OUT[4] = 1'b1; FPGA_DIR[4] = 1'b1;
        for (int d = 1; d <= 4; d++) expect_at("dirpulse_b4", d, S_SDIR, 8'h10, 8'h00);
        tick();
        FPGA_DIR[4] = 1'b0; FPGA_OUT[4] = 1'b0;
        ticks(4);

        // Reset during a filter count (bit 6) and a turnaround (bit 5)
        SOC_IN[6] = 1'b1;
        ticks(2);
        FPGA_OUT[5] = 1'b1; FPGA_DIR[5] = 1'b1;
        tick();
        RST = 1'b1;
        expect_at("rstmid_fin",   1, S_FIN,   8'hFF, 8'h00);
        expect_at("rstmid_sout",  1, S_SOUT,  8'hFF, 8'h00);
        expect_at("rstmid_sdir",  1, S_SDIR,  8'hFF, 8'h00);
        expect_at("rstmid_sdir0", 1, S_SDIR0, 8'hFF, 8'h00);
        tick();
        RST = 1'b0;
        expect_at("post_t0_dir",  1, S_SDIR0, 8'h24, 8'h24);
        expect_at("post_b5_dir1", 1, S_SDIR, 8'h20, 8'h00);
        expect_at("post_b5_dir2", 2, S_SDIR, 8'h20, 8'h00);
        expect_at("post_b5_dir3", 3, S_SDIR, 8'h20, 8'h20);
        expect_at("post_b6_pre",  FL - 1, S_FIN, 8'h41, 8'h00);
        expect_at("post_b6_rise", FL,     S_FIN, 8'h41, 8'h41);
        ticks(FL + 1);

        // All bits toggled together
        FPGA_DIR = '0; FPGA_OUT = '0; SOC_IN = '0;
        ticks(FL + 2);
        FPGA_DIR = 8'hFF; FPGA_OUT = 8'hA5; SOC_IN = 8'hFF;
        expect_at("all_dir_pre",  2, S_SDIR,  8'hFF, 8'h00);
        expect_at("all_dir",      3, S_SDIR,  8'hFF, 8'hFF);
        expect_at("all_out",      3, S_SOUT,  8'hFF, 8'hA5);
        expect_at("all_t0_dir",   1, S_SDIR0, 8'hFF, 8'hFF);
        expect_at("all_t0_out",   1, S_SOUT0, 8'hFF, 8'hA5);
        expect_at("all_fin_pre",  FL - 1, S_FIN,  8'hFF, 8'h00);
        expect_at("all_fin",      FL,     S_FIN,  8'hFF, 8'hFF);
        expect_at("all_fin0",     FL,     S_FIN0, 8'hFF, 8'hFF);

        // Drain the scoreboard within a bounded number of cycles
        for (int g = 0; g < 32 && sb.size() != 0; g++) tick();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
